// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state definitions for the 8-bit ALU and its
// command initiator.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'(ALU_XOR));
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR/XOR with zero, carry and signed
// overflow. SUB carry is the no-borrow flag (a >= b unsigned).
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [ALU_W-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [ALU_W:0] w_sum;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_sum    = '0;
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[ALU_W-1:0];
                o_carry  = w_sum[ALU_W];
                o_ovf    = (i_a[ALU_W-1] == i_b[ALU_W-1]) && (o_result[ALU_W-1] != i_a[ALU_W-1]);
            end
            ALU_SUB: begin
                w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{ALU_W{1'b0}}, 1'b1};
                o_result = w_sum[ALU_W-1:0];
                o_carry  = w_sum[ALU_W];
                o_ovf    = (i_a[ALU_W-1] != i_b[ALU_W-1]) && (o_result[ALU_W-1] != i_a[ALU_W-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_seq.sv
// Command initiator for the external ALU: registers operands, captures the
// result one cycle later and holds it on a valid/ready response port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] acc,
    input  logic              acc_clr,
    output logic [CNT_W-1:0]  op_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);

    seq_state_e        r_state, w_state_nxt;
    logic              w_ready, w_cmd_hs, w_legal_done;
    logic [DATA_W-1:0] r_alu_a, r_alu_b, r_acc;
    logic [2:0]        r_alu_op;
    logic [TAG_W-1:0]  r_tag, r_rsp_tag;
    logic              r_err;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero, r_rsp_carry, r_rsp_ovf, r_rsp_err;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                w_ready = rsp_ready;
                if (rsp_ready) w_state_nxt = cmd_valid ? EXEC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gated by rst_n so no command can appear accepted while reset is held.
    assign cmd_ready    = w_ready & rst_n;
    assign w_cmd_hs     = cmd_valid & cmd_ready;
    assign w_legal_done = (r_state == EXEC) & ~r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_tag    <= '0;
            r_err    <= 1'b0;
        end else if (w_cmd_hs) begin
            r_alu_a  <= cmd_use_acc ? r_acc : cmd_a;
            r_alu_b  <= cmd_b;
            r_alu_op <= cmd_op;
            r_tag    <= cmd_tag;
            r_err    <= ~is_legal_op(cmd_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_tag    <= '0;
        end else if (r_state == EXEC) begin
            r_rsp_tag <= r_tag;
            r_rsp_err <= r_err;
            if (r_err) begin
                r_rsp_result <= '0;
                r_rsp_zero   <= 1'b1;
                r_rsp_carry  <= 1'b0;
                r_rsp_ovf    <= 1'b0;
            end else begin
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
                r_rsp_carry  <= alu_carry;
                r_rsp_ovf    <= alu_ovf;
            end
        end
    end

    // Clear has priority over the result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_acc <= '0;
        else if (acc_clr)      r_acc <= '0;
        else if (w_legal_done) r_acc <= alu_result;
    end

    sat_cnt #(.CNT_W(CNT_W)) u_op_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_legal_done),
        .o_cnt (op_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_legal_done & alu_ovf),
        .o_cnt (ovf_cnt)
    );

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;
    assign rsp_tag    = r_rsp_tag;
    assign acc        = r_acc;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Command initiator for the 8-bit combinational ALU. Accepts operation commands on a valid/ready interface and drives registered operands and opcode to an ALU instance at the same hierarchy level. Captures the ALU result and flags, and returns them on a valid/ready response interface. Keeps an optional chaining accumulator and saturating event counters for status readout.

Parameters:
DATA_W, 8, operand/result width; only 8 is supported (matches ALU)
TAG_W, 4, width of the command tag returned with the response
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101-111 illegal
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_use_acc  in  1  replace operand A with the accumulator
cmd_tag  in  TAG_W  opaque tag echoed in the response
alu_a  out  DATA_W  registered operand to ALU
alu_b  out  DATA_W  registered operand to ALU
alu_op  out  3  registered opcode to ALU
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry_out
alu_ovf  in  1  ALU overflow
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_result  out  DATA_W  captured result; 0 on error
rsp_zero  out  1  captured zero flag
rsp_carry  out  1  captured carry
rsp_ovf  out  1  captured overflow
rsp_err  out  1  illegal opcode
rsp_tag  out  TAG_W  echoed tag
acc  out  DATA_W  accumulator value
acc_clr  in  1  synchronous accumulator clear
op_cnt  out  CNT_W  legal operations completed, saturating
ovf_cnt  out  CNT_W  responses with overflow=1, saturating

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE
  - alu_a, alu_b, alu_op, acc, op_cnt, ovf_cnt = 0
  - all rsp_* = 0; rsp_valid=0
  - cmd_ready=0 while rst_n is low, 1 in the first cycle after release.
- Reset mid-operation discards the in-flight command and any pending response; no partial response is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake: alu_a <= cmd_use_acc ? acc : cmd_a; alu_b <= cmd_b; alu_op <= cmd_op; tag and err flag (cmd_op > 3'b100) are latched. Go to EXEC.
- EXEC (one cycle):
  - cmd_ready=0.
  - Sample the ALU outputs into the rsp_* registers and set rsp_valid. Go to RESP.
  - If err: rsp_result=0, rsp_zero=1, carry=0, ovf=0; acc and counters unchanged.
  - If legal: acc <= alu_result; op_cnt++; ovf_cnt++ if alu_ovf. Counters stick at 2^CNT_W-1.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - cmd_ready = rsp_ready, giving a back-to-back path.
  - On rsp handshake without a new cmd: clear rsp_valid, go to IDLE.
  - On rsp handshake with a new cmd handshake in the same cycle: clear rsp_valid, latch the new cmd, go to EXEC.
- Latency: cmd handshake in cycle N, rsp_valid high in cycle N+2. Peak throughput is one command per 2 cycles.
- acc_clr:
  - Sets acc to 0 next cycle in any state.
  - If it coincides with the EXEC accumulator update, clear wins.
  - If it coincides with a cmd handshake using cmd_use_acc, the pre-clear acc value is used.
- alu_a, alu_b, alu_op hold their last values outside EXEC; they change only on a cmd handshake.
- rsp_valid never drops without a handshake. cmd_ready never depends combinationally on cmd_valid.

Decomposition:
- alu_pkg holds:
  - alu_op_e enum (ALU_ADD=3'b000 … ALU_XOR=3'b100)
  - ALU_W=8
  - is_legal_op() function
  - seq_state_e enum (IDLE, EXEC, RESP)
- One sub-module, sat_cnt: parameterised CNT_W saturating incrementer with inc and async active-low reset, instantiated twice for op_cnt and ovf_cnt.
- The ALU itself is instantiated beside alu_seq by the parent and by the bench, not inside it.

Test Plan:
- ADD a=0x7F b=0x01 -> rsp_result=0x80, ovf=1, carry=0, zero=0; ovf_cnt=1, op_cnt=1; rsp_valid exactly 2 cycles after the handshake.
- SUB a=0x05 b=0x05 tag=0xA -> result=0x00, zero=1, carry=1, ovf=0, rsp_tag=0xA; then ADD use_acc b=0xFF -> alu_a=0x00, result=0xFF.
- Chain: ADD 0x10+0x20, then use_acc ADD b=0x01, then use_acc XOR b=0xFF -> acc = 0x30, 0x31, 0xCE; acc_clr pulsed during the third EXEC -> acc=0x00.
- Illegal op 3'b110 a=0x12 b=0x34 -> rsp_err=1, result=0x00, zero=1; acc and op_cnt unchanged.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable and cmd_ready=0. Then rsp_ready high with cmd_valid high -> new cmd accepted same cycle, next rsp_valid 2 cycles later.
- Assert rst_n low during EXEC -> all outputs 0 immediately; after release no stale response appears and the next ADD 0x01+0x01 returns 0x02.
